// File: rtl/note_step_gen.sv
// rtl/note_step_gen.sv - MIDI note to per-voice NCO phase-step generator (sequential /12, octave shift)
// Optional per-voice glide slew toward the new target when GLIDE_EN is defined.
module note_step_gen #(
    parameter int VOICES      = 4,
    parameter int STEP_W      = 32,
    parameter int MAX_NOTE    = 88,
    parameter int GLIDE_SHIFT = 4,
    parameter int VIDX_W      = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [VIDX_W-1:0]        req_voice_i,
    input  logic [6:0]               req_note_i,
    input  logic                     glide_tick_i,
    output logic [VOICES*STEP_W-1:0] step_o,
    output logic                     upd_valid_o,
    output logic [VIDX_W-1:0]        upd_voice_o
);
    typedef enum logic [2:0] {IDLE, DIV, LOOK, SHIFT, WRITE} state_t;

    localparam logic [6:0]      MAX_N = 7'(MAX_NOTE);
    localparam logic [VIDX_W:0] NUM_V = (VIDX_W+1)'(VOICES);

    state_t            state;
    logic [VIDX_W-1:0] voice;
    logic [6:0]        rem;
    logic [2:0]        oct;
    logic [23:0]       base;
    logic [STEP_W-1:0] result;
    logic [STEP_W-1:0] target [VOICES];
    logic              wr_en;

    // Steps for the top octave (notes 84..95); lower octaves are right shifts of these.
    function automatic logic [23:0] top_octave(input logic [3:0] semi);
        case (semi)
            4'd0:    return 24'd4756588;
            4'd1:    return 24'd5039428;
            4'd2:    return 24'd5339088;
            4'd3:    return 24'd5656566;
            4'd4:    return 24'd5992924;
            4'd5:    return 24'd6349282;
            4'd6:    return 24'd6726830;
            4'd7:    return 24'd7126828;
            4'd8:    return 24'd7550610;
            4'd9:    return 24'd7999594;
            4'd10:   return 24'd8475274;
            default: return 24'd8979240;
        endcase
    endfunction

    assign req_ready_o = (state == IDLE);
    assign wr_en       = (state == WRITE) && ({1'b0, voice} < NUM_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            voice       <= '0;
            rem         <= '0;
            oct         <= '0;
            base        <= '0;
            result      <= '0;
            upd_valid_o <= 1'b0;
            upd_voice_o <= '0;
        end else begin
            upd_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        voice <= req_voice_i;
                        if (req_note_i == 7'd0 || req_note_i > MAX_N) begin
                            result <= '0;
                            state  <= WRITE;
                        end else begin
                            rem   <= req_note_i;
                            oct   <= '0;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (rem >= 7'd12) begin
                        rem <= rem - 7'd12;
                        oct <= oct + 3'd1;
                    end else begin
                        state <= LOOK;
                    end
                end
                LOOK: begin
                    base  <= top_octave(rem[3:0]);
                    state <= SHIFT;
                end
                SHIFT: begin
                    result <= STEP_W'(base >> (3'd7 - oct));
                    state  <= WRITE;
                end
                WRITE: begin
                    if (wr_en) begin
                        upd_valid_o <= 1'b1;
                        upd_voice_o <= voice;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VOICES; v++) target[v] <= '0;
        end else if (wr_en) begin
            for (int v = 0; v < VOICES; v++) begin
                if (voice == VIDX_W'(v)) target[v] <= result;
            end
        end
    end

`ifdef GLIDE_EN
    localparam logic signed [STEP_W:0] SNAP = $signed((STEP_W+1)'(1) << GLIDE_SHIFT);

    logic [STEP_W-1:0]        current [VOICES];
    logic signed [STEP_W:0]   diff    [VOICES];
    logic [STEP_W-1:0]        slewed  [VOICES];

    // Within one slew quantum of the target we snap, so convergence is exact.
    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            diff[v] = $signed({1'b0, target[v]}) - $signed({1'b0, current[v]});
            if (diff[v] < SNAP && diff[v] > -SNAP) slewed[v] = target[v];
            else slewed[v] = current[v] + STEP_W'(diff[v] >>> GLIDE_SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VOICES; v++) current[v] <= '0;
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (wr_en && voice == VIDX_W'(v) && (result == '0 || current[v] == '0))
                    current[v] <= result;
                else if (glide_tick_i)
                    current[v] <= slewed[v];
            end
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_step
        assign step_o[g*STEP_W +: STEP_W] = current[g];
    end
`else
    logic [1:0] unused_cfg;
    assign unused_cfg = {glide_tick_i, 1'(GLIDE_SHIFT)};

    for (genvar g = 0; g < VOICES; g++) begin : g_step
        assign step_o[g*STEP_W +: STEP_W] = target[g];
    end
`endif
endmodule

// File: doc/note_step_gen.md
Name: note_step_gen

Overview:
Multi-voice MIDI-note to phase-step generator for the NCO bank. It accepts note requests over a valid/ready handshake and computes each step from a 12-entry top-octave table plus an octave right-shift, using a sequential divide-by-12. Each voice's step is held in a register that drives the per-voice phase accumulators. An optional glide stage slews each voice's step toward its new target.

Parameters:
VOICES, 4, number of voices; VIDX_W = max(1, clog2(VOICES))
STEP_W, 32, step width in bits; must be >= 24
MAX_NOTE, 88, highest valid note; range 1..95
GLIDE_SHIFT, 4, glide slew divisor exponent (GLIDE_EN only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  note request valid
req_ready_o  out  1  high only in IDLE
req_voice_i  in  VIDX_W  target voice
req_note_i  in  7  MIDI note; 0 = silence
glide_tick_i  in  1  glide update strobe; ignored without GLIDE_EN
step_o  out  VOICES*STEP_W  per-voice step; voice v at bits [v*STEP_W +: STEP_W]
upd_valid_o  out  1  one-cycle pulse when a target is written
upd_voice_o  out  VIDX_W  voice written with that pulse

Behaviour:
- Reset (async, active-low): all target and current steps = 0; FSM = IDLE; req_ready_o = 1; upd_valid_o = 0; upd_voice_o = 0. Assertion at any point aborts an in-flight request with no update pulse.
- Base table, semitones 0..11: 4756588, 5039428, 5339088, 5656566, 5992924, 6349282, 6726830, 7126828, 7550610, 7999594, 8475274, 8979240. Values are zero-extended to STEP_W.
- Valid note: step = table[note mod 12] >> (7 - note div 12), a logical shift with truncation.
- FSM states: IDLE, DIV, LOOK, SHIFT, WRITE.
- IDLE:
  - On req_valid_i & req_ready_o, capture voice and note (accept edge E0).
  - If note = 0 or note > MAX_NOTE: result = 0, go to WRITE.
  - Otherwise: rem = note, oct = 0, go to DIV.
- DIV: if rem >= 12, then rem -= 12 and oct += 1, staying in DIV; else go to LOOK.
- LOOK: base = table[rem]; go to SHIFT.
- SHIFT: result = base >> (7 - oct); go to WRITE.
- WRITE: on the next edge, target[voice] = result, upd_valid_o = 1 for exactly one cycle, upd_voice_o = voice, go to IDLE.
- Latency:
  - Valid note: target updates at edge E0 + oct + 4.
  - Zero or out-of-range note: target updates at edge E0 + 1.
  - Next request can be accepted at the edge after the update edge.
- req_valid_i while req_ready_o = 0 is ignored. The requester holds the request; no request queueing.
- Only the addressed voice changes; all other voices hold.
- Without GLIDE_EN: current = target, and step_o reflects the new value in the cycle after the update edge.
- Requests for a voice index >= VOICES are consumed with no register write and no update pulse.

Optional Feature:
Macro GLIDE_EN.
- Defined:
  - On each glide_tick_i, every voice with current != target updates current += (target - current) >>> GLIDE_SHIFT (signed arithmetic shift).
  - If |target - current| < 2^GLIDE_SHIFT, current snaps to target.
  - A target write of 0, or a write while current = 0, snaps current immediately at the update edge.
  - step_o = current.
- Undefined: no current registers exist, step_o = target, and glide_tick_i is unused.

Test Plan:
- Reset -> step_o all 0, req_ready_o = 1, upd_valid_o = 0.
- Voice 2, note 69 -> voice 2 step = 1999898 at E0+9; upd_valid_o high one cycle with upd_voice_o = 2; voices 0, 1, 3 unchanged.
- Voice 0 note 1 -> 39370 at E0+4. Voice 3 note 88 -> 5992924 at E0+11. Voice 1 note 89 (MAX_NOTE = 88) -> 0 at E0+1. Voice 1 note 0 -> 0 at E0+1.
- Hold req_valid_i with a changing note while busy -> only the note present at the accept edge is used; req_ready_o is low from E0 until the update edge.
- Assert rst_n low during DIV -> all steps 0, no upd_valid_o pulse, req_ready_o = 1 after release.
- GLIDE_EN, GLIDE_SHIFT = 4:
  - Voice 0 note 57 -> snaps to 999949.
  - Then note 69 plus one glide_tick_i -> step = 1062445.
  - Repeated ticks converge exactly to 1999898.
